seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIV, default 50000: FPGA_CLK cycles per digit slot (1 kHz per digit, 250 Hz frame at 50 MHz); legal range DIV > GUARD.
REQ-002 Parameter GUARD, default 500: cycles at the start of each slot with all digits off (anti-ghosting); legal range GUARD >= 1.
REQ-003 FPGA_CLK  in  1  sole clock, 50 MHz.
REQ-004 RESET_BUT  in  1  reset, synchronous, active-low.
REQ-005 load  in  1  high for one cycle = capture data and dp_mask into shadow.
REQ-006 data  in  16  four hex nibbles; data[3:0] = digit 0 (rightmost), data[15:12] = digit 3.
REQ-007 dp_mask  in  4  decimal point per digit, 1 = lit.
REQ-008 blank  in  1  1 = all digits off; scanning continues.
REQ-009 DIG  out  4  digit enables, active-low; DIG[0] drives DIG_1.
REQ-010 SEG  out  8  segments, active-low; SEG[0..6] = a..g, SEG[7] = dp.
REQ-011 frame_done  out  1  one-cycle pulse per completed 4-digit frame.

Function
REQ-012 Slot counter cnt counts 0..DIV-1 and wraps to 0; digit index idx advances mod 4 on every wrap.
REQ-013 Slot FSM has two states: GUARD for cnt < GUARD (DIG = 4'b1111), then ON for cnt >= GUARD (DIG[idx] = 0, other bits 1).
REQ-014 All outputs are registered, with one cycle of latency from cnt/idx/display state.
REQ-015 SEG shows the hex decode of display nibble idx, plus dp from display dp_mask[idx]; SEG = 8'hFF during GUARD.
REQ-016 Decode values (dp off): 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90, A = 88, b = 83, C = C6, d = A1, E = 86, F = 8E.
REQ-017 When load = 1, data and dp_mask are written into the shadow register and a pending flag is set.
REQ-018 On the frame boundary (cnt = DIV-1 and idx = 3), shadow is copied to the display register when pending = 1, and pending is cleared.
REQ-019 When load coincides with the frame-boundary cycle, the data presented in that cycle is copied to the display register and pending ends cleared.
REQ-020 Repeated loads within one frame: the last one wins; no tearing within a frame.
REQ-021 frame_done goes high for exactly one cycle, in the cycle after each frame boundary.
REQ-022 blank = 1 forces DIG = 4'b1111 and SEG = 8'hFF on the next cycle; cnt, idx and frame_done are unaffected.

Reset
REQ-023 RESET_BUT = 0 at a FPGA_CLK edge sets: cnt = 0, idx = 0, display = 0, display dp = 0, shadow = 0, pending = 0.
REQ-024 The outputs after reset are DIG = 4'b1111, SEG = 8'hFF and frame_done = 0.
REQ-025 Reset asserted mid-slot or mid-frame discards any pending load; scanning restarts at digit 0, GUARD state, on the first cycle after release.

Configuration
REQ-026 Macro SEG7_LZ_BLANK_EN defined: leading-zero blanking is enabled. A digit stays off (DIG bit 1, SEG FF) for its whole slot when it is zero and every more-significant digit is also zero. Digit 0 is never blanked, and dp_mask does not override blanking.
REQ-027 Macro SEG7_LZ_BLANK_EN undefined: every digit is always displayed, including leading zeros.

Verification (DIV=10, GUARD=2)
REQ-028 Reset release, no load -> per slot: 2 cycles with DIG=1111 and SEG=FF, then 8 cycles with DIG one-cold at idx and SEG=C0; frame_done pulses every 40 cycles.
REQ-029 load with data=16'h12AF and dp_mask=4'b0100 mid-frame -> the old value is held until the frame boundary. The next frame shows digit0 = 8E, digit1 = 88, digit2 = 24 (dp on), digit3 = F9.
REQ-030 Two loads in one frame (16'h1111, then 16'h2222); load coincident with the boundary cycle -> the next frame shows only 2222; the coincident value appears in the frame immediately after the boundary.
REQ-031 blank = 1 for 25 cycles -> DIG = 1111 throughout; frame_done timing is unchanged; the correct digit resumes once blank returns to 0.
REQ-032 With SEG7_LZ_BLANK_EN: data = 16'h0030 -> digits 3 and 2 stay dark, digit1 = B0, digit0 = C0. data = 0 -> only digit 0 is lit, showing C0.
REQ-033 RESET_BUT low for 1 cycle at idx = 2 with a load pending -> next cycle DIG = 1111 and SEG = FF; scanning restarts at idx = 0 and display = 0.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed 7-segment scanner with per-slot guard time and frame-synchronous display update.
// Build option: define SEG7_LZ_BLANK_EN to turn on leading-zero blanking.
module seg7_scan #(
    parameter int DIV   = 50000,
    parameter int GUARD = 500
) (
    input  logic        FPGA_CLK,
    input  logic        RESET_BUT,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_mask,
    input  logic        blank,
    output logic [3:0]  DIG,
    output logic [7:0]  SEG,
    output logic        frame_done
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD - 1);

    typedef enum logic {S_GUARD, S_ON} slot_e;

    slot_e            state_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic [1:0]       idx_p0;
    logic [15:0]      disp_p0;
    logic [3:0]       disp_dp_p0;
    logic [15:0]      shadow_p0;
    logic [3:0]       shadow_dp_p0;
    logic             pending_p0;

    logic [3:0]       dig_p1;
    logic [7:0]       seg_p1;
    logic             fd_p1;

    logic             slot_end;
    logic             frame_end;
    logic             digit_off;
    logic [3:0]       nib;
    logic [7:0]       seg_dec;

    function automatic logic [7:0] hex_decode(input logic [3:0] n, input logic dp);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return {~dp, s};
    endfunction

`ifdef SEG7_LZ_BLANK_EN
    // A digit is dark when it and every more-significant nibble are zero; digit 0 always shows.
    function automatic logic lz_dark(input logic [15:0] d, input logic [1:0] i);
        logic dark;
        case (i)
            2'd3:    dark = (d[15:12] == 4'h0);
            2'd2:    dark = (d[15:8] == 8'h00);
            2'd1:    dark = (d[15:4] == 12'h000);
            default: dark = 1'b0;
        endcase
        return dark;
    endfunction

    assign digit_off = blank || lz_dark(disp_p0, idx_p0);
`else
    assign digit_off = blank;
`endif

    assign slot_end  = (cnt_p0 == CNT_LAST);
    assign frame_end = slot_end && (idx_p0 == 2'd3);

    always_comb begin
        nib = 4'h0;
        case (idx_p0)
            2'd0: nib = disp_p0[3:0];
            2'd1: nib = disp_p0[7:4];
            2'd2: nib = disp_p0[11:8];
            2'd3: nib = disp_p0[15:12];
            default: nib = 4'h0;
        endcase
    end

    assign seg_dec = hex_decode(nib, disp_dp_p0[idx_p0]);

    // p0: slot counter, digit index and guard/on state
    // p1: registered digit/segment drive and frame pulse
    always_ff @(posedge FPGA_CLK) begin
        if (!RESET_BUT) begin
            state_p0 <= S_GUARD;
            cnt_p0   <= '0;
            idx_p0   <= 2'd0;
            dig_p1   <= 4'hF;
            seg_p1   <= 8'hFF;
            fd_p1    <= 1'b0;
        end else begin
            dig_p1 <= 4'hF;
            seg_p1 <= 8'hFF;
            if (state_p0 == S_ON && !digit_off) begin
                dig_p1 <= ~(4'b0001 << idx_p0);
                seg_p1 <= seg_dec;
            end
            fd_p1 <= frame_end;

            if (slot_end) begin
                cnt_p0   <= '0;
                idx_p0   <= idx_p0 + 2'd1;
                state_p0 <= S_GUARD;
            end else begin
                cnt_p0 <= cnt_p0 + 1'b1;
                if (cnt_p0 == GRD_LAST)
                    state_p0 <= S_ON;
            end
        end
    end

    // p0: shadow capture and frame-boundary transfer into the display register
    always_ff @(posedge FPGA_CLK) begin
        if (!RESET_BUT) begin
            disp_p0      <= 16'h0000;
            disp_dp_p0   <= 4'h0;
            shadow_p0    <= 16'h0000;
            shadow_dp_p0 <= 4'h0;
            pending_p0   <= 1'b0;
        end else begin
            if (load) begin
                shadow_p0    <= data;
                shadow_dp_p0 <= dp_mask;
            end
            if (frame_end) begin
                pending_p0 <= 1'b0;
                if (load) begin
                    disp_p0    <= data;
                    disp_dp_p0 <= dp_mask;
                end else if (pending_p0) begin
                    disp_p0    <= shadow_p0;
                    disp_dp_p0 <= shadow_dp_p0;
                end
            end else if (load) begin
                pending_p0 <= 1'b1;
            end
        end
    end

    assign DIG        = dig_p1;
    assign SEG        = seg_p1;
    assign frame_done = fd_p1;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan at DIV=10, GUARD=2, plus directed frame-content checks.
// Honours SEG7_LZ_BLANK_EN in both the reference model and the directed expectations.
module tb_seg7_scan;
    localparam int P_DIV   = 10;
    localparam int P_GUARD = 2;

    logic        FPGA_CLK = 1'b0;
    logic        RESET_BUT = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic        blank = 1'b0;
    logic [3:0]  DIG;
    logic [7:0]  SEG;
    logic        frame_done;

    seg7_scan #(.DIV(P_DIV), .GUARD(P_GUARD)) dut (
        .FPGA_CLK   (FPGA_CLK),
        .RESET_BUT  (RESET_BUT),
        .load       (load),
        .data       (data),
        .dp_mask    (dp_mask),
        .blank      (blank),
        .DIG        (DIG),
        .SEG        (SEG),
        .frame_done (frame_done)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    typedef struct packed {
        logic [3:0] dig;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_disp = 16'h0;
    logic [3:0]  m_dp = 4'h0;
    logic [15:0] m_sh = 16'h0;
    logic [3:0]  m_shdp = 4'h0;
    logic        m_pend = 1'b0;

    logic [7:0]  fseg [4];
    logic        flit [4];

    function automatic logic [7:0] ref_dec(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs for the coming edge, from model state and the inputs now driven.
    task automatic model_push();
        exp_t        e;
        logic [3:0]  n;
        logic [15:0] upper;
        logic        off;
        if (!RESET_BUT) begin
            e = '{dig: 4'hF, seg: 8'hFF, fd: 1'b0};
        end else begin
            n     = m_disp[4*m_idx +: 4];
            upper = m_disp >> (4 * m_idx);
            off   = (m_cnt < P_GUARD) || blank;
`ifdef SEG7_LZ_BLANK_EN
            if (m_idx != 0 && upper == 16'h0) off = 1'b1;
`endif
            e.fd = (m_cnt == P_DIV - 1) && (m_idx == 3);
            if (off) begin
                e.dig = 4'hF;
                e.seg = 8'hFF;
            end else begin
                e.dig = 4'hF;
                e.dig[m_idx] = 1'b0;
                e.seg = ref_dec(n);
                if (m_dp[m_idx]) e.seg[7] = 1'b0;
            end
        end
        sbq.push_back(e);
    endtask

    task automatic model_update();
        logic bnd;
        if (!RESET_BUT) begin
            m_cnt = 0; m_idx = 0; m_disp = 16'h0; m_dp = 4'h0;
            m_sh = 16'h0; m_shdp = 4'h0; m_pend = 1'b0;
        end else begin
            bnd = (m_cnt == P_DIV - 1) && (m_idx == 3);
            if (bnd) begin
                if (load) begin
                    m_disp = data; m_dp = dp_mask;
                end else if (m_pend) begin
                    m_disp = m_sh; m_dp = m_shdp;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            if (load) begin
                m_sh = data; m_shdp = dp_mask;
            end
            if (m_cnt == P_DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 16'(sbq.size()), 16'd1);
        end else begin
            e = sbq.pop_front();
            chk("sb_dig", {12'h0, DIG}, {12'h0, e.dig});
            chk("sb_seg", {8'h0, SEG}, {8'h0, e.seg});
            chk("sb_fd", {15'h0, frame_done}, {15'h0, e.fd});
        end
    endtask

    task automatic step();
        model_push();
        @(posedge FPGA_CLK);
        model_update();
        @(negedge FPGA_CLK);
        check_pop();
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("sync_frame_done", {15'h0, frame_done}, 16'h0001);
    endtask

    task automatic capture_frame(input logic ld_last, input logic [15:0] d_last);
        logic [3:0] oc;
        for (int d = 0; d < 4; d++) begin
            fseg[d] = 8'h00;
            flit[d] = 1'b0;
        end
        for (int i = 0; i < 4 * P_DIV; i++) begin
            if (i == 4 * P_DIV - 1 && ld_last) begin
                load = 1'b1; data = d_last; dp_mask = 4'h0;
            end
            step();
            load = 1'b0;
            for (int d = 0; d < 4; d++) begin
                oc = ~(4'b0001 << d);
                if (DIG === oc) begin
                    fseg[d] = SEG;
                    flit[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                             input logic [7:0] s1, input logic [7:0] s0);
        chk({tag, "_d3"}, {8'h0, fseg[3]}, {8'h0, s3});
        chk({tag, "_d2"}, {8'h0, fseg[2]}, {8'h0, s2});
        chk({tag, "_d1"}, {8'h0, fseg[1]}, {8'h0, s1});
        chk({tag, "_d0"}, {8'h0, fseg[0]}, {8'h0, s0});
    endtask

    initial begin
        // Reset held for three edges
        RESET_BUT = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rst_dig", {12'h0, DIG}, 16'h000F);
        chk("rst_seg", {8'h0, SEG}, 16'h00FF);
        chk("rst_fd", {15'h0, frame_done}, 16'h0000);

        // Release: guard, guard, then digit 0 showing 0
        RESET_BUT = 1'b1;
        for (int k = 1; k <= 4 * P_DIV; k++) begin
            step();
            if (k == 2) chk("rel_guard_dig", {12'h0, DIG}, 16'h000F);
            if (k == 3) begin
                chk("rel_on_dig", {12'h0, DIG}, 16'h000E);
                chk("rel_on_seg", {8'h0, SEG}, 16'h00C0);
            end
            if (k == 12) chk("slot1_guard", {12'h0, DIG}, 16'h000F);
            if (k == 13) chk("slot1_on", {12'h0, DIG}, 16'h000D);
            if (k == 39) chk("fd_before", {15'h0, frame_done}, 16'h0000);
            if (k == 40) chk("fd_first", {15'h0, frame_done}, 16'h0001);
        end
        capture_frame(1'b0, 16'h0);
        chk_frame("zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        chk("fd_period", {15'h0, frame_done}, 16'h0001);

        // Mid-frame load is held back until the frame boundary
        for (int i = 0; i < 15; i++) step();
        load = 1'b1; data = 16'h12AF; dp_mask = 4'b0100;
        step();
        load = 1'b0;
        chk("held_old_seg", {8'h0, SEG}, 16'h00C0);
        sync_frame();
        capture_frame(1'b0, 16'h0);
        chk_frame("12AF", 8'hF9, 8'h24, 8'h88, 8'h8E);

        // Two loads in one frame, then a load on the boundary cycle itself
        load = 1'b1; data = 16'h1111; dp_mask = 4'h0;
        step();
        load = 1'b0;
        for (int i = 0; i < 9; i++) step();
        load = 1'b1; data = 16'h2222;
        step();
        load = 1'b0;
        sync_frame();
        capture_frame(1'b1, 16'h3333);
        chk_frame("last_wins", 8'hA4, 8'hA4, 8'hA4, 8'hA4);
        chk("fd_coincident", {15'h0, frame_done}, 16'h0001);
        capture_frame(1'b0, 16'h0);
        chk_frame("coincident", 8'hB0, 8'hB0, 8'hB0, 8'hB0);

        // Blank for 25 cycles mid-frame
        for (int k = 1; k <= 4 * P_DIV; k++) begin
            blank = (k >= 8 && k <= 32);
            step();
            if (k >= 8 && k <= 32) chk("blank_dig", {12'h0, DIG}, 16'h000F);
            if (k == 33) begin
                chk("unblank_dig", {12'h0, DIG}, 16'h0007);
                chk("unblank_seg", {8'h0, SEG}, 16'h00B0);
            end
            if (k == 40) chk("blank_fd", {15'h0, frame_done}, 16'h0001);
        end
        blank = 1'b0;

        // Leading zeros
        load = 1'b1; data = 16'h0030; dp_mask = 4'h0;
        step();
        load = 1'b0;
        sync_frame();
        capture_frame(1'b0, 16'h0);
`ifdef SEG7_LZ_BLANK_EN
        chk("lz30_d3_dark", {15'h0, flit[3]}, 16'h0000);
        chk("lz30_d2_dark", {15'h0, flit[2]}, 16'h0000);
        chk("lz30_d1", {8'h0, fseg[1]}, 16'h00B0);
        chk("lz30_d0", {8'h0, fseg[0]}, 16'h00C0);
`else
        chk_frame("lz30", 8'hC0, 8'hC0, 8'hB0, 8'hC0);
`endif
        load = 1'b1; data = 16'h0000;
        step();
        load = 1'b0;
        sync_frame();
        capture_frame(1'b0, 16'h0);
`ifdef SEG7_LZ_BLANK_EN
        chk("lz0_d3_dark", {15'h0, flit[3]}, 16'h0000);
        chk("lz0_d2_dark", {15'h0, flit[2]}, 16'h0000);
        chk("lz0_d1_dark", {15'h0, flit[1]}, 16'h0000);
        chk("lz0_d0", {8'h0, fseg[0]}, 16'h00C0);
`else
        chk_frame("lz0", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

        // Reset pulse at idx 2 with a load pending
        load = 1'b1; data = 16'h5678; dp_mask = 4'hF;
        step();
        load = 1'b0;
        for (int i = 0; i < 24; i++) step();
        RESET_BUT = 1'b0;
        step();
        chk("mid_rst_dig", {12'h0, DIG}, 16'h000F);
        chk("mid_rst_seg", {8'h0, SEG}, 16'h00FF);
        RESET_BUT = 1'b1;
        step();
        step();
        chk("post_rst_guard", {12'h0, DIG}, 16'h000F);
        step();
        chk("post_rst_dig0", {12'h0, DIG}, 16'h000E);
        chk("post_rst_seg0", {8'h0, SEG}, 16'h00C0);
        sync_frame();
        capture_frame(1'b0, 16'h0);
        chk_frame("pend_dropped", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
